// File: rtl/keypad_digit_buffer_pkg.sv
// rtl/keypad_digit_buffer_pkg.sv - shared types and default command codes for the keypad digit buffer
package keypad_pkg;

    typedef enum logic [1:0] {KP_IDLE, KP_HELD, KP_REPEAT} kp_state_t;

    typedef enum {ACT_NONE, ACT_DATA, ACT_CLR, ACT_BKSP} kp_action_t;

    localparam logic [3:0] KP_DEFAULT_CLR_CODE  = 4'hC;
    localparam logic [3:0] KP_DEFAULT_BKSP_CODE = 4'hB;

endpackage

// File: rtl/keypad_digit_buffer_if.sv
// rtl/keypad_digit_buffer_if.sv - scanner-side key inputs and display-side digit outputs
interface keypad_digit_buffer_if #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4
) ();
    localparam int CW = $clog2(NUM_DIGITS + 1);

    logic [DIGIT_W-1:0]            key_code;
    logic                          key_valid;
    logic [NUM_DIGITS*DIGIT_W-1:0] digits;
    logic [CW-1:0]                 digit_count;
    logic                          entry_strobe;
    logic                          overflow;

    modport master (
        output key_code, key_valid,
        input  digits, digit_count, entry_strobe, overflow
    );

    modport slave (
        input  key_code, key_valid,
        output digits, digit_count, entry_strobe, overflow
    );
endinterface

// File: rtl/keypad_digit_buffer_press_fsm.sv
// rtl/keypad_digit_buffer_press_fsm.sv - press tracking; KEYPAD_AUTOREPEAT_EN adds hold counter and REPEAT state
module keypad_press_fsm
    import keypad_pkg::*;
#(
    parameter int DIGIT_W = 4
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    parameter logic [15:0] REPEAT_DELAY = 16'd500,
    parameter logic [15:0] REPEAT_RATE  = 16'd100
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_code,
    output logic               apply,
    output logic [DIGIT_W-1:0] apply_code
);

    kp_state_t state;

`ifdef KEYPAD_AUTOREPEAT_EN
    logic [15:0]        hold_cnt;
    logic [DIGIT_W-1:0] held_code;
    logic               delay_hit;
    logic               rate_hit;

    assign delay_hit = (hold_cnt == 16'(REPEAT_DELAY - 16'd1));
    assign rate_hit  = (hold_cnt == 16'(REPEAT_RATE - 16'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= KP_IDLE;
            hold_cnt  <= '0;
            held_code <= '0;
        end else begin
            case (state)
                KP_IDLE: begin
                    hold_cnt <= '0;
                    if (key_valid) begin
                        state     <= KP_HELD;
                        held_code <= key_code;
                    end
                end
                KP_HELD: begin
                    if (!key_valid) begin
                        state    <= KP_IDLE;
                        hold_cnt <= '0;
                    end else if (delay_hit) begin
                        state    <= KP_REPEAT;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 16'd1;
                    end
                end
                KP_REPEAT: begin
                    if (!key_valid) begin
                        state    <= KP_IDLE;
                        hold_cnt <= '0;
                    end else if (rate_hit) begin
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 16'd1;
                    end
                end
                default: begin
                    state    <= KP_IDLE;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    // Repeats reuse the code captured at the original press, never the live key_code.
    assign apply = key_valid && ((state == KP_IDLE) ||
                                 (state == KP_HELD && delay_hit) ||
                                 (state == KP_REPEAT && rate_hit));
    assign apply_code = (state == KP_IDLE) ? key_code : held_code;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= KP_IDLE;
        end else begin
            case (state)
                KP_IDLE: if (key_valid)  state <= KP_HELD;
                KP_HELD: if (!key_valid) state <= KP_IDLE;
                default: state <= KP_IDLE;
            endcase
        end
    end

    assign apply      = key_valid && (state == KP_IDLE);
    assign apply_code = key_code;
`endif

endmodule

// File: rtl/keypad_digit_buffer.sv
// rtl/keypad_digit_buffer.sv - N-digit keypad entry buffer with clear/backspace keys
// Optional auto-repeat of held keys when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_digit_buffer
    import keypad_pkg::*;
#(
    parameter int                 NUM_DIGITS   = 4,
    parameter int                 DIGIT_W      = 4,
    parameter int                 CMD_KEYS     = 1,
    parameter logic [DIGIT_W-1:0] CLR_CODE     = DIGIT_W'(KP_DEFAULT_CLR_CODE),
    parameter logic [DIGIT_W-1:0] BKSP_CODE    = DIGIT_W'(KP_DEFAULT_BKSP_CODE),
    parameter logic [15:0]        REPEAT_DELAY = 16'd500,
    parameter logic [15:0]        REPEAT_RATE  = 16'd100
) (
    input logic                clk,
    input logic                rst,
    keypad_digit_buffer_if.slave kp
);

    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam int DW = NUM_DIGITS * DIGIT_W;

    if (NUM_DIGITS < 2 || REPEAT_DELAY == 16'd0 || REPEAT_RATE == 16'd0) begin : g_bad_params
        $error("keypad_digit_buffer: NUM_DIGITS must be >= 2 and repeat timings non-zero");
    end

    logic               apply;
    logic [DIGIT_W-1:0] apply_code;
    kp_action_t         action;

    logic [DW-1:0] digits_q;
    logic [CW-1:0] count_q;
    logic          strobe_q;
    logic          overflow_q;

    keypad_press_fsm #(
        .DIGIT_W      (DIGIT_W)
`ifdef KEYPAD_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
`endif
    ) u_press_fsm (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (kp.key_valid),
        .key_code   (kp.key_code),
        .apply      (apply),
        .apply_code (apply_code)
    );

    always_comb begin
        action = ACT_NONE;
        if (apply) begin
            if (CMD_KEYS != 0 && apply_code == CLR_CODE)
                action = ACT_CLR;
            else if (CMD_KEYS != 0 && apply_code == BKSP_CODE)
                action = ACT_BKSP;
            else
                action = ACT_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digits_q   <= '0;
            count_q    <= '0;
            strobe_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            strobe_q   <= (action != ACT_NONE);
            overflow_q <= 1'b0;
            case (action)
                ACT_DATA: begin
                    digits_q <= {digits_q[DW-DIGIT_W-1:0], apply_code};
                    // A full buffer means the oldest valid digit is being pushed out.
                    if (count_q == CW'(NUM_DIGITS))
                        overflow_q <= 1'b1;
                    else
                        count_q <= count_q + CW'(1);
                end
                ACT_CLR: begin
                    digits_q <= '0;
                    count_q  <= '0;
                end
                ACT_BKSP: begin
                    digits_q <= {{DIGIT_W{1'b0}}, digits_q[DW-1:DIGIT_W]};
                    if (count_q != '0)
                        count_q <= count_q - CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign kp.digits       = digits_q;
    assign kp.digit_count  = count_q;
    assign kp.entry_strobe = strobe_q;
    assign kp.overflow     = overflow_q;

endmodule

// File: tb/tb_keypad_digit_buffer.sv
// tb/tb_keypad_digit_buffer.sv - directed bench with behavioural model; command-key and plain-data instances
module tb_keypad_digit_buffer;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif
    localparam int RDELAY = 10;
    localparam int RRATE  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    int stb_cnt = 0;
    int ovf_cnt = 0;

    always #5 clk = ~clk;

    keypad_digit_buffer_if #(.NUM_DIGITS(4), .DIGIT_W(4)) bus_a ();
    keypad_digit_buffer_if #(.NUM_DIGITS(4), .DIGIT_W(4)) bus_b ();

    assign bus_a.key_valid = key_valid;
    assign bus_a.key_code  = key_code;
    assign bus_b.key_valid = key_valid;
    assign bus_b.key_code  = key_code;

    keypad_digit_buffer #(
        .NUM_DIGITS(4), .DIGIT_W(4), .CMD_KEYS(1), .CLR_CODE(4'hC), .BKSP_CODE(4'hB),
        .REPEAT_DELAY(16'(RDELAY)), .REPEAT_RATE(16'(RRATE))
    ) dut_a (.clk(clk), .rst(rst), .kp(bus_a));

    keypad_digit_buffer #(
        .NUM_DIGITS(4), .DIGIT_W(4), .CMD_KEYS(0), .CLR_CODE(4'hC), .BKSP_CODE(4'hB),
        .REPEAT_DELAY(16'(RDELAY)), .REPEAT_RATE(16'(RRATE))
    ) dut_b (.clk(clk), .rst(rst), .kp(bus_b));

    // Model: per instance, a list of four digits (index 0 newest) and a count.
    int md [2][4];
    int mc [2];
    bit ms [2];
    bit mo [2];
    int held = -1;
    int pcode = 0;

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_apply(input int idx, input int code);
        bit cmd;
        cmd = (idx == 0);
        ms[idx] = 1'b1;
        if (cmd && code == 12) begin
            for (int i = 0; i < 4; i++) md[idx][i] = 0;
            mc[idx] = 0;
        end else if (cmd && code == 11) begin
            for (int i = 0; i < 3; i++) md[idx][i] = md[idx][i+1];
            md[idx][3] = 0;
            if (mc[idx] > 0) mc[idx] = mc[idx] - 1;
        end else begin
            mo[idx] = (mc[idx] == 4);
            for (int i = 3; i > 0; i--) md[idx][i] = md[idx][i-1];
            md[idx][0] = code;
            if (mc[idx] < 4) mc[idx] = mc[idx] + 1;
        end
    endtask

    function automatic int exp_digits(input int idx);
        return md[idx][0] | (md[idx][1] << 4) | (md[idx][2] << 8) | (md[idx][3] << 12);
    endfunction

    // A key held for h edges fires at h=0 and, with auto-repeat, at DELAY, DELAY+RATE, ...
    function automatic bit fires(input int h);
        return (h == 0) || (AR && h >= RDELAY && ((h - RDELAY) % RRATE) == 0);
    endfunction

    initial forever begin
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            ms[k] = 1'b0;
            mo[k] = 1'b0;
        end
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 4; i++) md[k][i] = 0;
                mc[k] = 0;
            end
            held = -1;
        end else if (key_valid) begin
            held = (held < 0) ? 0 : held + 1;
            if (held == 0) pcode = int'(key_code);
            if (fires(held)) begin
                model_apply(0, pcode);
                model_apply(1, pcode);
            end
        end else begin
            held = -1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            cmp("a_digits",   int'(bus_a.digits),       exp_digits(0));
            cmp("a_count",    int'(bus_a.digit_count),  mc[0]);
            cmp("a_strobe",   int'(bus_a.entry_strobe), int'(ms[0]));
            cmp("a_overflow", int'(bus_a.overflow),     int'(mo[0]));
            cmp("b_digits",   int'(bus_b.digits),       exp_digits(1));
            cmp("b_count",    int'(bus_b.digit_count),  mc[1]);
            cmp("b_strobe",   int'(bus_b.entry_strobe), int'(ms[1]));
            cmp("b_overflow", int'(bus_b.overflow),     int'(mo[1]));
            stb_cnt += int'(bus_a.entry_strobe);
            ovf_cnt += int'(bus_a.overflow);
        end
    end

    task automatic drive(input bit kv, input int code);
        @(negedge clk);
        rst       = 1'b0;
        key_valid = kv;
        key_code  = code[3:0];
    endtask

    task automatic press(input int code);
        repeat (3) drive(1'b1, code);
        repeat (2) drive(1'b0, 0);
    endtask

    int s0;
    int exp_cnt;

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        cmp("rst_digits", int'(bus_a.digits), 0);
        cmp("rst_count",  int'(bus_a.digit_count), 0);
        cmp("rst_strobe", int'(bus_a.entry_strobe), 0);
        cmp("rst_ovf",    int'(bus_a.overflow), 0);

        s0 = stb_cnt;
        press(1); press(2); press(3);
        cmp("seq123_digits", int'(bus_a.digits), 32'h0123);
        cmp("seq123_count",  int'(bus_a.digit_count), 3);
        cmp("seq123_strobes", stb_cnt - s0, 3);

        repeat (25) drive(1'b1, 5);
        repeat (25) drive(1'b1, 7);
        repeat (2) drive(1'b0, 0);
        cmp("hold5_low_nibble", int'(bus_a.digits[3:0]), 5);
`ifndef KEYPAD_AUTOREPEAT_EN
        cmp("hold5_digits", int'(bus_a.digits), 32'h1235);
`endif

        press(12);
        press(4); press(3); press(2); press(1);
        cmp("full_digits", int'(bus_a.digits), 32'h4321);
        cmp("full_count",  int'(bus_a.digit_count), 4);
        s0 = ovf_cnt;
        press(9);
        cmp("ovf_digits", int'(bus_a.digits), 32'h3219);
        cmp("ovf_count",  int'(bus_a.digit_count), 4);
        cmp("ovf_pulses", ovf_cnt - s0, 1);
        press(11);
        cmp("bksp_digits", int'(bus_a.digits), 32'h0321);
        cmp("bksp_count",  int'(bus_a.digit_count), 3);
        press(9);
        press(12);
        cmp("clr_digits", int'(bus_a.digits), 0);
        cmp("clr_count",  int'(bus_a.digit_count), 0);
        s0 = stb_cnt;
        press(11);
        cmp("bksp0_count",  int'(bus_a.digit_count), 0);
        cmp("bksp0_strobe", stb_cnt - s0, 1);
        cmp("b_bksp_data",  int'(bus_b.digits[3:0]), 4'hB);
        press(12);
        cmp("b_clr_data",   int'(bus_b.digits[3:0]), 4'hC);

        repeat (3) drive(1'b1, 6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cmp("rst_held_digits", int'(bus_a.digits), 0);
        cmp("rst_held_count",  int'(bus_a.digit_count), 0);
        cmp("rst_held_strobe", int'(bus_a.entry_strobe), 0);
        @(negedge clk);
        cmp("post_rst_digits", int'(bus_a.digits), 6);
        cmp("post_rst_count",  int'(bus_a.digit_count), 1);
        cmp("post_rst_strobe", int'(bus_a.entry_strobe), 1);
        repeat (2) drive(1'b0, 0);

        press(12);
        drive(1'b1, 6);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            cmp("hold_strobe", int'(bus_a.entry_strobe),
                int'((i == 0) || (AR && (i == 10 || i == 14 || i == 18 || i == 22 || i == 26))));
            if (i == 29) key_valid = 1'b0;
        end
        @(negedge clk);
        cmp("release_strobe", int'(bus_a.entry_strobe), 0);
        exp_cnt = AR ? 4 : 1;
        cmp("hold_count", int'(bus_a.digit_count), exp_cnt);
        repeat (2) drive(1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
